// File: rtl/pll_reconfig_ctrl.sv
// rPLL dynamic reconfiguration sequencer on the reference clock: gates clk_en,
// holds PLL reset, applies codes, waits for lock (retry, fallback), re-enables.
module pll_reconfig_ctrl #(
  parameter logic [5:0] DEF_IDSEL     = 6'd61,
  parameter logic [5:0] DEF_FBDSEL    = 6'd52,
  parameter logic [5:0] DEF_ODSEL     = 6'd56,
  parameter logic [3:0] DEF_DUTYDA    = 4'b1000,
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_TIMEOUT  = 4096,
  parameter int         SETTLE_CYCLES = 256,
  parameter int         MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_req,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  output logic       cfg_ack,
  output logic       cfg_busy,
  output logic       cfg_err,
  output logic       locked,
  output logic       clk_en,
  output logic [1:0] retry_cnt,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       pll_reset_p,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda
);

  localparam int TW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int CMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock_s counts as locked cycle one.
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 2);
  localparam logic [TW-1:0] TMO      = TW'(LOCK_TIMEOUT);
  localparam logic [1:0]    MAX_R    = 2'(MAX_RETRY);
  localparam logic [25:0]   DEFC     = {DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL,
                                        4'd0, DEF_DUTYDA};

  typedef enum logic [2:0] {
    IDLE, RST_HOLD, WAIT_LOCK, SETTLE, FALLBACK
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    sync;
  logic          lock_s;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tmr, tmr_nx, tmr_inc;
  logic [1:0]    retry_nx;
  logic [25:0]   sh, sh_nx, sel, sel_nx;
  logic          fb, fb_nx;
  logic          boot, boot_nx;
  logic          clk_en_nx, locked_nx, ack_nx, err_nx;

  assign lock_s      = sync[1];
  assign cfg_busy    = (state != IDLE);
  assign pll_reset   = (state == RST_HOLD);
  assign pll_reset_p = (state == RST_HOLD);
  assign {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda} = sel;
  assign tmr_inc = (tmr == TMO) ? TMO : tmr + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_HOLD;
      sync      <= 2'b00;
      cnt       <= '0;
      tmr       <= '0;
      retry_cnt <= 2'd0;
      sh        <= DEFC;
      sel       <= DEFC;
      fb        <= 1'b0;
      boot      <= 1'b1;
      clk_en    <= 1'b0;
      locked    <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      sync      <= {sync[0], pll_lock};
      cnt       <= cnt_nx;
      tmr       <= tmr_nx;
      retry_cnt <= retry_nx;
      sh        <= sh_nx;
      sel       <= sel_nx;
      fb        <= fb_nx;
      boot      <= boot_nx;
      clk_en    <= clk_en_nx;
      locked    <= locked_nx;
      cfg_ack   <= ack_nx;
      cfg_err   <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    tmr_nx    = tmr;
    retry_nx  = retry_cnt;
    sh_nx     = sh;
    sel_nx    = sel;
    fb_nx     = fb;
    boot_nx   = boot;
    clk_en_nx = clk_en;
    locked_nx = locked;
    ack_nx    = 1'b0;
    err_nx    = cfg_err;
    unique case (state)
      IDLE: begin
        if (cfg_req) begin
          sh_nx     = {cfg_idsel, cfg_fbdsel, cfg_odsel,
                       cfg_psda, cfg_dutyda};
          clk_en_nx = 1'b0;
          locked_nx = 1'b0;
          retry_nx  = 2'd0;
          err_nx    = 1'b0;
          fb_nx     = 1'b0;
          boot_nx   = 1'b0;
          cnt_nx    = '0;
          state_nx  = RST_HOLD;
        end else if (locked && !lock_s) begin
          locked_nx = 1'b0;
          clk_en_nx = 1'b0;
        end
      end
      RST_HOLD: begin
        sel_nx = sh;
        if (cnt == RST_LAST) begin
          cnt_nx   = '0;
          tmr_nx   = '0;
          state_nx = WAIT_LOCK;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          cnt_nx   = '0;
          state_nx = SETTLE;
        end else begin
          tmr_nx = tmr_inc;
          if (tmr_inc == TMO) begin
            if (fb) begin
              clk_en_nx = 1'b0;
              locked_nx = 1'b0;
              ack_nx    = !boot;
              state_nx  = IDLE;
            end else if (retry_cnt < MAX_R) begin
              retry_nx = retry_cnt + 2'd1;
              cnt_nx   = '0;
              state_nx = RST_HOLD;
            end else begin
              state_nx = FALLBACK;
            end
          end
        end
      end
      SETTLE: begin
        // Timer is kept frozen here so a lock drop resumes its budget.
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
        end else if (cnt >= SET_LAST) begin
          clk_en_nx = 1'b1;
          locked_nx = 1'b1;
          ack_nx    = !boot;
          state_nx  = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      FALLBACK: begin
        sh_nx    = DEFC;
        err_nx   = 1'b1;
        fb_nx    = 1'b1;
        cnt_nx   = '0;
        state_nx = RST_HOLD;
      end
      default: state_nx = RST_HOLD;
    endcase
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Sequences the dynamic divider and phase/duty settings of the on-chip rPLL and brings it out of reset.
- Runs on the PLL reference clock (24 MHz board clock), not on any PLL output.
- A host (CSR block) requests a new configuration. The block gates downstream clocks, holds the PLL in reset, applies the codes, waits for lock with timeout and retry, then re-enables the clocks.
- On persistent failure it falls back to the power-on defaults.

Parameters:
DEF_IDSEL, 6'd61, power-on/fallback IDSEL code (raw rPLL dynamic encoding)
DEF_FBDSEL, 6'd52, power-on/fallback FBDSEL code
DEF_ODSEL, 6'd56, power-on/fallback ODSEL code
DEF_DUTYDA, 4'b1000, power-on DUTYDA code
RST_CYCLES, 16, cycles pll_reset is held high (>=2)
LOCK_TIMEOUT, 4096, cycles to wait for synchronised lock after reset release
SETTLE_CYCLES, 256, cycles lock must stay high before clk_en asserts
MAX_RETRY, 3, extra reset attempts before fallback

Ports:
clk  in  1  reference clock
rst_n  in  1  asynchronous active-low reset
cfg_req  in  1  level request; sampled only in IDLE
cfg_idsel  in  6  requested IDSEL code
cfg_fbdsel  in  6  requested FBDSEL code
cfg_odsel  in  6  requested ODSEL code
cfg_psda  in  4  requested phase code
cfg_dutyda  in  4  requested duty code
cfg_ack  out  1  one-cycle pulse when a request completes (success or fallback)
cfg_busy  out  1  high in every state except IDLE
cfg_err  out  1  sticky; set on fallback, cleared on next accepted cfg_req
locked  out  1  high in IDLE only when the last bring-up succeeded
clk_en  out  1  downstream clock-gate enable
retry_cnt  out  2  attempts used in the current/last sequence
pll_lock  in  1  rPLL LOCK (asynchronous)
pll_reset, pll_reset_p  out  1 each  rPLL RESET / RESET_P
pll_idsel, pll_fbdsel, pll_odsel  out  6 each  rPLL dynamic selects
pll_psda, pll_dutyda  out  4 each  rPLL dynamic phase/duty

Behaviour:
- pll_lock passes through a 2-FF synchroniser (lock_s) before any use. Added latency: 2 cycles.
- Reset values:
  - state=RST_HOLD; pll_reset=pll_reset_p=1.
  - pll_* selects = DEF_* values; pll_psda=0.
  - clk_en=0, locked=0, cfg_busy=1, cfg_ack=0, cfg_err=0, retry_cnt=0.
  - All counters 0.
- States: IDLE, RST_HOLD, WAIT_LOCK, SETTLE, FALLBACK.
- IDLE + cfg_req=1:
  - Latch all cfg_* into shadow registers.
  - Next cycle: clk_en=0, locked=0, retry_cnt=0, cfg_err=0. Enter RST_HOLD.
- RST_HOLD:
  - pll_reset=pll_reset_p=1.
  - pll_* selects driven from shadow registers (or defaults after fallback); they change only in this state.
  - After RST_CYCLES cycles, deassert both resets and enter WAIT_LOCK with the timer cleared.
- WAIT_LOCK:
  - lock_s=1 -> SETTLE, counter cleared.
  - Timer reaches LOCK_TIMEOUT -> if retry_cnt<MAX_RETRY: retry_cnt+1, return to RST_HOLD with the same codes; else -> FALLBACK.
- SETTLE:
  - lock_s drop -> back to WAIT_LOCK. The timer is NOT cleared; it continues from its value.
  - SETTLE_CYCLES consecutive cycles with lock_s=1 -> IDLE. Same edge: clk_en=1, locked=1, cfg_ack pulse.
- FALLBACK:
  - Load DEF_* into the shadow registers and set cfg_err.
  - Run one RST_HOLD/WAIT_LOCK/SETTLE pass with no retries.
  - Success -> IDLE: cfg_ack, clk_en=1, locked=1, cfg_err stays 1.
  - Timeout -> IDLE: clk_en=0, locked=0, cfg_ack pulses.
- Lock loss in IDLE (lock_s=0 while locked=1): locked=0 and clk_en=0 next cycle. No automatic reconfiguration; the host must re-request.
- cfg_req while busy is ignored, not queued. cfg_req held high re-triggers one cycle after cfg_ack.
- After rst_n deassert: auto bring-up with defaults. No cfg_ack for this boot sequence; the first IDLE entry sets locked/clk_en.
- rst_n asserted mid-sequence: immediate return to reset values, shadow registers = defaults.
- Counters saturate and never wrap. Timer width = clog2(LOCK_TIMEOUT+1).

Test Plan:
1. Boot: release rst_n, lock model asserts 100 cycles after reset release -> pll_reset high exactly 16 cycles, clk_en=1 after 2+256 further cycles, no cfg_ack.
2. Reconfig: in IDLE, cfg_req with idsel=6'd62, fbdsel=6'd40, odsel=6'd60 -> clk_en falls next cycle, pll_* take the new values while pll_reset=1, cfg_ack single pulse, locked=1, cfg_err=0.
3. Retry: lock never asserts for the first two attempts, then asserts -> retry_cnt=2, success, cfg_err=0.
4. Fallback: lock never asserts -> 4 attempts with requested codes, then DEF_* codes applied. If the model locks on defaults: cfg_err=1, locked=1, cfg_ack pulses once.
5. Glitch: lock drops for 5 cycles mid-SETTLE -> settle count restarts, clk_en delayed accordingly. Lock loss in IDLE -> clk_en=0 within 3 cycles of the pll_lock fall.
6. rst_n pulse during WAIT_LOCK -> all outputs return to reset values at once (async), defaults reloaded, bring-up restarts.
